// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Power-of-two circular FIFO with flush, used to buffer fetched {instr, pc} pairs.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential imem requests, buffers in-order responses,
// and discards responses belonging to requests issued before a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    data_width = 32,
  parameter logic [data_width-1:0] RESET_PC   = '0,
  parameter int                    FQ_DEPTH   = 4,
  parameter int                    MAX_OUT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [data_width-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [data_width-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [data_width-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] instr_reg_fetch,
  output logic [data_width-1:0] pc_fetch,
  output logic [data_width-1:0] npc_fetch
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int QW = $clog2(FQ_DEPTH) + 1;
  localparam logic [data_width-1:0] PC_STEP = data_width'(INSTR_BYTES);

  fetch_state_e          state_q,   state_d;
  logic [data_width-1:0] fpc_q,     fpc_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic [CW-1:0]         drop_q,    drop_d;
  logic [CW-1:0]         cnt_post;

  logic                    req_fire, out_fire;
  logic                    fifo_push, fifo_flush, fifo_full, fifo_empty;
  logic [QW-1:0]           fifo_count;
  logic [data_width-1:0]   rsp_pc;
  logic [2*data_width-1:0] fifo_head;

  // Occupancy plus in-flight requests never exceeds the queue depth, so every response has a slot.
  assign imem_req_valid = !rst && (state_q == RUN) && !redirect_valid
                        && (out_cnt_q < CW'(MAX_OUT))
                        && ((32'(fifo_count) + 32'(out_cnt_q)) < 32'(FQ_DEPTH));
  assign imem_req_addr  = fpc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_fire       = out_valid && out_ready;
  assign cnt_post       = out_cnt_q + CW'(req_fire) - CW'(imem_rsp_valid);

  // Responses are in order and contiguous since the last redirect, so the oldest one's PC is implied.
  assign rsp_pc = fpc_q - data_width'(out_cnt_q) * PC_STEP;

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    drop_d     = drop_q;
    out_cnt_d  = cnt_post;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (redirect_valid) begin
      fifo_flush = 1'b1;
      fpc_d      = redirect_pc & ~(PC_STEP - 1'b1);
      drop_d     = cnt_post;
      state_d    = (cnt_post != '0) ? DRAIN : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (req_fire) fpc_d = fpc_q + PC_STEP;
          fifo_push = imem_rsp_valid && !fifo_full;
        end
        DRAIN: begin
          if (imem_rsp_valid) begin
            drop_d = drop_q - 1'b1;
            if (drop_q == CW'(1)) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      fpc_q     <= RESET_PC;
      out_cnt_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      out_cnt_q <= out_cnt_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH (2*data_width),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (out_fire),
    .flush     (fifo_flush),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid       = !fifo_empty;
  assign instr_reg_fetch = fifo_head[2*data_width-1:data_width];
  assign pc_fetch        = fifo_head[data_width-1:0];
  assign npc_fetch       = pc_fetch + PC_STEP;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory model plus a queue-level
// reference of which requests are live and what decode should see.
module tb_fetch_unit;

  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] instr_reg_fetch, pc_fetch, npc_fetch;

  always #5 clk = ~clk;

  fetch_unit #(
    .data_width (W),
    .RESET_PC   (RPC),
    .FQ_DEPTH   (DEPTH),
    .MAX_OUT    (MAXO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .instr_reg_fetch (instr_reg_fetch),
    .pc_fetch        (pc_fetch),
    .npc_fetch       (npc_fetch)
  );

  // Each accepted request: address the DUT sent, PC the model expected, and whether a redirect orphaned it.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] mpc;
    bit          stale;
    int          born;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  mreq_t       mem_q[$];
  ent_t        fq[$];
  logic [31:0] m_fpc;
  int          cyc;
  int          pass_cnt;
  int          total_cnt;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, compare settled outputs, then advance the model past the next posedge.
  task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                      input bit oready, input bit qready, input int rsp_pct);
    bit    do_rsp, stale_any, exp_rv, req_fire, out_fire;
    mreq_t m;
    ent_t  e;
    @(negedge clk);
    rst            = r;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = oready;
    imem_req_ready = qready;
    do_rsp = !r && (mem_q.size() > 0) && (mem_q[0].born < cyc)
           && (int'($urandom_range(99)) < rsp_pct);
    imem_rsp_valid = do_rsp;
    imem_rsp_data  = do_rsp ? hash(mem_q[0].addr) : $urandom;
    #1;
    stale_any = 1'b0;
    foreach (mem_q[i]) if (mem_q[i].stale) stale_any = 1'b1;
    exp_rv = !r && !redir && !stale_any && (mem_q.size() < MAXO)
           && ((fq.size() + mem_q.size()) < DEPTH);
    check("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("imem_req_addr", imem_req_addr, m_fpc);
    check("out_valid", 32'(out_valid), 32'(fq.size() > 0));
    if (fq.size() > 0) begin
      check("pc_fetch", pc_fetch, fq[0].pc);
      check("instr_reg_fetch", instr_reg_fetch, fq[0].instr);
      check("npc_fetch", npc_fetch, fq[0].pc + 32'd4);
    end

    req_fire = imem_req_valid && qready;
    out_fire = (fq.size() > 0) && oready;
    if (r) begin
      mem_q.delete();
      fq.delete();
      m_fpc = RPC;
    end else begin
      if (do_rsp) begin
        m = mem_q.pop_front();
        if (!m.stale && !redir) begin
          check("rsp_into_full_queue", 32'(fq.size() < DEPTH), 32'd1);
          e.pc    = m.mpc;
          e.instr = hash(m.mpc);
        end
      end
      if (out_fire) void'(fq.pop_front());
      if (do_rsp && !m.stale && !redir) fq.push_back(e);
      if (req_fire) begin
        mem_q.push_back('{addr: imem_req_addr, mpc: m_fpc, stale: 1'b0, born: cyc});
        m_fpc = m_fpc + 32'd4;
      end
      if (redir) begin
        fq.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        m_fpc = rpc & ~32'h3;
      end
    end
    cyc++;
  endtask

  initial begin
    int guard;
    bit r, rd;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    m_fpc = RPC; cyc = 0; pass_cnt = 0; total_cnt = 0;

    repeat (3) step(1, 0, '0, 1, 1, 0);

    // Zero-wait streaming from RESET_PC, wrapping through 0.
    repeat (16) step(0, 0, '0, 1, 1, 100);

    // Decode stalls: queue fills to depth, requests stop, then drain in order.
    repeat (20) step(0, 0, '0, 0, 1, 100);
    repeat (12) step(0, 0, '0, 1, 1, 100);

    // Redirect to 0x100 with both request slots in flight.
    guard = 0;
    while (mem_q.size() < MAXO && guard < 10) begin
      step(0, 0, '0, 1, 1, 0);
      guard++;
    end
    check("outstanding_reached", 32'(mem_q.size()), 32'(MAXO));
    step(0, 1, 32'h0000_0100, 1, 1, 0);
    repeat (12) step(0, 0, '0, 1, 1, 100);

    // Redirect with a response landing in the same cycle, then a misaligned target.
    repeat (2) step(0, 0, '0, 1, 1, 0);
    step(0, 1, 32'h0000_0400, 1, 1, 100);
    repeat (6) step(0, 0, '0, 1, 1, 100);
    step(0, 1, 32'h0000_0203, 1, 1, 0);
    repeat (10) step(0, 0, '0, 1, 1, 100);

    // Single-cycle reset mid-stream with request stalls.
    repeat (8) step(0, 0, '0, 1, ($urandom_range(1) == 1), 70);
    step(1, 0, '0, 1, 0, 0);
    repeat (10) step(0, 0, '0, 1, ($urandom_range(1) == 1), 70);

    // Random mix of stalls, redirects (including during drain) and resets.
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(99) == 0);
      rd = !r && ($urandom_range(14) == 0);
      step(r, rd, $urandom, ($urandom_range(3) != 0), ($urandom_range(2) != 0), 60);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter data_width, default 32, SHALL set the PC and instruction width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 Parameter FQ_DEPTH, default 4, SHALL set the fetch-queue depth; it SHALL be a power of two and at least 2.
REQ-004 Parameter MAX_OUT, default 2, SHALL set the maximum number of outstanding imem requests; it SHALL be at least 1 and no greater than FQ_DEPTH.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 imem_req_valid  out  1  fetch request valid.
REQ-008 imem_req_ready  in  1  memory accepts the request.
REQ-009 imem_req_addr  out  data_width  fetch byte address.
REQ-010 imem_rsp_valid  in  1  response valid; responses arrive in order, at least 1 cycle after acceptance.
REQ-011 imem_rsp_data  in  data_width  instruction word.
REQ-012 redirect_valid  in  1  branch/jump/exception redirect from a later stage.
REQ-013 redirect_pc  in  data_width  redirect target.
REQ-014 out_valid  out  1  instr_reg_fetch, pc_fetch and npc_fetch are valid.
REQ-015 out_ready  in  1  decode accepts the instruction.
REQ-016 instr_reg_fetch, pc_fetch, npc_fetch  out  data_width each  instruction, its PC, and PC+4.

Function
REQ-017 A request SHALL be accepted on a cycle with imem_req_valid && imem_req_ready; a response on imem_rsp_valid; the output on out_valid && out_ready.
REQ-018 The block SHALL keep a fetch PC (fpc), an outstanding counter (0..MAX_OUT), a drop counter, and a FQ_DEPTH-entry FIFO of {instr, pc}.
REQ-019 States SHALL be RUN and DRAIN; reset enters RUN.
REQ-020 In RUN, imem_req_valid SHALL be 1 iff outstanding < MAX_OUT and (FIFO occupancy + outstanding) < FQ_DEPTH, with imem_req_addr = fpc.
REQ-021 Once raised, imem_req_valid and imem_req_addr SHALL hold until acceptance unless redirect_valid is asserted.
REQ-022 On request acceptance, fpc SHALL advance by 4, modulo 2^data_width; 0xFFFF_FFFC SHALL wrap to 0.
REQ-023 A non-dropped response SHALL be pushed into the FIFO with the PC of its request; outstanding SHALL be incremented on acceptance, decremented on response, and unchanged when both occur in the same cycle.
REQ-024 out_valid SHALL equal FIFO-not-empty; the outputs SHALL come from the FIFO head, with npc_fetch = pc_fetch + 4 (wrapping); the head SHALL pop on the output handshake.
REQ-025 When the FIFO is empty, a response SHALL NOT bypass it; minimum latency from response to out_valid SHALL be 1 cycle.
REQ-026 On redirect_valid, the FIFO SHALL be flushed and fpc loaded with {redirect_pc[data_width-1:2], 2'b00}.
REQ-027 On redirect_valid, the drop counter SHALL be loaded with the post-cycle outstanding count: current, +1 if a request is accepted this cycle, -1 if a response arrives this cycle.
REQ-028 On redirect_valid, the next state SHALL be DRAIN if the drop counter is nonzero, else RUN.
REQ-029 A response arriving in the redirect cycle SHALL be discarded.
REQ-030 In the redirect cycle and in DRAIN, imem_req_valid SHALL be 0.
REQ-031 In DRAIN, each response SHALL be discarded and decrement both counters; at drop counter 1 with a response, the state SHALL return to RUN.
REQ-032 A redirect in DRAIN SHALL reload fpc and recompute the drop counter per REQ-027.
REQ-033 An output handshake in a redirect cycle SHALL complete (decode owns that instruction); out_valid SHALL be 0 the next cycle.
REQ-034 A response arriving with a full FIFO cannot occur by REQ-020; verification SHALL assert on it.

Reset
REQ-035 While rst is high at a clock edge, the block SHALL load fpc=RESET_PC, outstanding=0, drop=0, FIFO empty, state RUN, imem_req_valid=0, out_valid=0.
REQ-036 The first request SHALL be raised on the first cycle after rst deasserts, with address RESET_PC.
REQ-037 Reset mid-operation SHALL abandon all outstanding requests; the memory model SHALL be reset on the same rst.

Structure
REQ-038 Package fetch_pkg SHALL hold INSTR_BYTES=4, the state enum {RUN, DRAIN}, and NOP_INSTR=32'h0000_0013.
REQ-039 The FIFO SHALL be a sub-module fetch_fifo, parametrised by width and depth, with push, pop, flush, full, empty and count.

Verification
REQ-040 Zero-wait memory, out_ready=1, RESET_PC=0 -> pc_fetch 0,4,8,… on consecutive cycles after 2-cycle startup; npc_fetch = pc_fetch+4.
REQ-041 out_ready=0 for 20 cycles -> exactly FQ_DEPTH(4) entries buffered, imem_req_valid=0, no response lost; resume yields PCs in order.
REQ-042 Redirect to 0x100 with 2 requests outstanding -> next 2 responses dropped, first output pc_fetch=0x100, no stale PC ever emitted.
REQ-043 redirect_pc=0x203 -> first fetch address 0x200.
REQ-044 RESET_PC=0xFFFF_FFF8 -> pc_fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; npc_fetch of FFFF_FFFC = 0.
REQ-045 rst asserted for 1 cycle mid-stream with random imem_req_ready stalls -> outputs restart at RESET_PC, out_valid low the cycle after reset.
